// File: rtl/defog_airlight_ctrl.sv
// Frame-level airlight controller: tracks the per-frame dark-channel maximum,
// validates frame geometry and publishes a smoothed, clamped airlight at frame boundaries.
module defog_airlight_ctrl #(
  parameter int H_ACTIVE     = 1920,
  parameter int V_ACTIVE     = 1080,
  parameter int VS_POL       = 1,
  parameter int SMOOTH_SHIFT = 2,
  parameter int A_MIN        = 128,
  parameter int A_DEFAULT    = 255
) (
  input  logic        pixelclk,
  input  logic        reset,
  input  logic [7:0]  i_dark,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic        i_de,
  input  logic        cfg_en,
  input  logic        cfg_manual,
  input  logic [7:0]  cfg_manual_a,
  output logic [7:0]  o_dark_max,
  output logic        o_valid,
  output logic        o_bypass,
  output logic        o_frame_done,
  output logic        o_frame_err,
  output logic [15:0] o_frame_cnt
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_SYNC   = 2'd1;
  localparam logic [1:0]  ST_ACCUM  = 2'd2;
  localparam logic [1:0]  ST_UPDATE = 2'd3;

  localparam logic        VS_ACT     = 1'(VS_POL);
  localparam logic [21:0] PIX_EXPECT = 22'(H_ACTIVE * V_ACTIVE);
  localparam logic [7:0]  A_MIN_C    = 8'(A_MIN);
  localparam logic [7:0]  A_DEF_C    = 8'(A_DEFAULT);

  logic [1:0]  state_r;
  logic        vs_r;
  logic [7:0]  frame_max_r;
  logic [21:0] pix_cnt_r;
  logic [7:0]  max_snap_r;
  logic [21:0] cnt_snap_r;
  logic        manual_snap_r;
  logic [7:0]  manual_a_snap_r;

  logic              edge_s;
  logic [7:0]        acc_max_s;
  logic [21:0]       pix_inc_s;
  logic signed [8:0] diff_s;
  logic signed [8:0] shr_s;
  logic signed [8:0] step_s;
  logic signed [9:0] sum_s;
  logic signed [9:0] pre_s;
  logic [7:0]        a_new_s;

  // Frame edge detection and running accumulator next values.
  always_comb begin
    edge_s    = (i_vsync == VS_ACT) && (vs_r != VS_ACT);
    acc_max_s = (i_dark > frame_max_r) ? i_dark : frame_max_r;
    pix_inc_s = (pix_cnt_r == 22'h3FFFFF) ? pix_cnt_r : (pix_cnt_r + 22'd1);
  end

  // IIR step with a forced unit step so small differences still converge, then clamp.
  always_comb begin
    diff_s = $signed({1'b0, max_snap_r}) - $signed({1'b0, o_dark_max});
    shr_s  = diff_s >>> SMOOTH_SHIFT;
    if ((diff_s != 9'sd0) && (shr_s == 9'sd0)) begin
      step_s = diff_s[8] ? -9'sd1 : 9'sd1;
    end else begin
      step_s = shr_s;
    end
    sum_s = $signed({2'b00, o_dark_max}) + $signed({step_s[8], step_s});
    if (o_valid) begin
      pre_s = sum_s;
    end else begin
      pre_s = $signed({2'b00, max_snap_r});
    end
    if (pre_s < $signed({2'b00, A_MIN_C})) begin
      a_new_s = A_MIN_C;
    end else if (pre_s > 10'sd255) begin
      a_new_s = 8'd255;
    end else begin
      a_new_s = pre_s[7:0];
    end
  end

  // Frame FSM, accumulators, boundary snapshots and registered outputs.
  always_ff @(posedge pixelclk) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      vs_r            <= VS_ACT;
      frame_max_r     <= 8'd0;
      pix_cnt_r       <= 22'd0;
      max_snap_r      <= 8'd0;
      cnt_snap_r      <= 22'd0;
      manual_snap_r   <= 1'b0;
      manual_a_snap_r <= 8'd0;
      o_dark_max      <= A_DEF_C;
      o_valid         <= 1'b0;
      o_bypass        <= 1'b1;
      o_frame_done    <= 1'b0;
      o_frame_err     <= 1'b0;
      o_frame_cnt     <= 16'd0;
    end else begin
      vs_r         <= i_vsync;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
      if (!cfg_en) begin
        // Disable aborts any frame in flight; o_dark_max is kept for the datapath.
        state_r     <= ST_IDLE;
        frame_max_r <= 8'd0;
        pix_cnt_r   <= 22'd0;
        o_valid     <= 1'b0;
        o_bypass    <= 1'b1;
        o_frame_cnt <= 16'd0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_SYNC;
          end
          ST_SYNC: begin
            if (edge_s) begin
              frame_max_r <= i_de ? i_dark : 8'd0;
              pix_cnt_r   <= i_de ? 22'd1 : 22'd0;
              state_r     <= ST_ACCUM;
            end
          end
          ST_ACCUM: begin
            if (edge_s) begin
              max_snap_r      <= frame_max_r;
              cnt_snap_r      <= pix_cnt_r;
              manual_snap_r   <= cfg_manual;
              manual_a_snap_r <= cfg_manual_a;
              frame_max_r     <= i_de ? i_dark : 8'd0;
              pix_cnt_r       <= i_de ? 22'd1 : 22'd0;
              state_r         <= ST_UPDATE;
            end else if (i_de) begin
              frame_max_r <= acc_max_s;
              pix_cnt_r   <= pix_inc_s;
            end
          end
          ST_UPDATE: begin
            state_r      <= ST_ACCUM;
            o_frame_done <= 1'b1;
            if (i_de) begin
              frame_max_r <= acc_max_s;
              pix_cnt_r   <= pix_inc_s;
            end
            if (manual_snap_r) begin
              o_dark_max <= manual_a_snap_r;
              o_bypass   <= 1'b0;
            end else if (cnt_snap_r != PIX_EXPECT) begin
              o_frame_err <= 1'b1;
              o_bypass    <= ~o_valid;
            end else begin
              o_dark_max  <= a_new_s;
              o_valid     <= 1'b1;
              o_bypass    <= 1'b0;
              o_frame_cnt <= o_frame_cnt + 16'd1;
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_defog_airlight_ctrl.sv
// Directed self-checking bench for defog_airlight_ctrl with a 4x2 frame geometry.
module tb_defog_airlight_ctrl;

  logic        pixelclk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  i_dark = 8'd0;
  logic        i_hsync = 1'b0;
  logic        i_vsync = 1'b0;
  logic        i_de = 1'b0;
  logic        cfg_en = 1'b0;
  logic        cfg_manual = 1'b0;
  logic [7:0]  cfg_manual_a = 8'd0;
  logic [7:0]  o_dark_max;
  logic        o_valid;
  logic        o_bypass;
  logic        o_frame_done;
  logic        o_frame_err;
  logic [15:0] o_frame_cnt;

  int checks = 0;
  int errors = 0;

  defog_airlight_ctrl #(
    .H_ACTIVE(4), .V_ACTIVE(2), .VS_POL(1), .SMOOTH_SHIFT(2), .A_MIN(128), .A_DEFAULT(255)
  ) dut (
    .pixelclk(pixelclk), .reset(reset), .i_dark(i_dark), .i_hsync(i_hsync),
    .i_vsync(i_vsync), .i_de(i_de), .cfg_en(cfg_en), .cfg_manual(cfg_manual),
    .cfg_manual_a(cfg_manual_a), .o_dark_max(o_dark_max), .o_valid(o_valid),
    .o_bypass(o_bypass), .o_frame_done(o_frame_done), .o_frame_err(o_frame_err),
    .o_frame_cnt(o_frame_cnt)
  );

  always #5 pixelclk = ~pixelclk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge pixelclk);
    #1;
  endtask

  task automatic send_pixels(input int n, input logic [7:0] mx);
    for (int i = 0; i < n; i++) begin
      i_de   = 1'b1;
      i_dark = (i == 1 || n == 1) ? mx : (mx >> 1);
      i_hsync = (i % 4 == 0);
      tick();
    end
    i_de    = 1'b0;
    i_dark  = 8'd0;
    i_hsync = 1'b0;
  endtask

  task automatic vs_pulse();
    i_vsync = 1'b1;
    tick();
    i_vsync = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (o_dark_max !== 8'd255) begin errors++; $display("FAIL reset_dark: got %0d expected 255", o_dark_max); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    checks++; if (o_bypass !== 1'b1) begin errors++; $display("FAIL reset_bypass: got %b expected 1", o_bypass); end
    checks++; if (o_frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", o_frame_cnt); end
    checks++; if ({o_frame_done, o_frame_err} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b expected 00", {o_frame_done, o_frame_err}); end
    reset  = 1'b0;
    cfg_en = 1'b1;
    tick();
    send_pixels(3, 8'd77);
    vs_pulse();
    checks++; if (o_frame_done !== 1'b0) begin errors++; $display("FAIL partial_done: got %b expected 0", o_frame_done); end
    checks++; if (o_dark_max !== 8'd255) begin errors++; $display("FAIL partial_dark: got %0d expected 255", o_dark_max); end
  endtask

  task automatic test_good_frame();
    send_pixels(8, 8'd200);
    vs_pulse();
    checks++; if (o_dark_max !== 8'd200) begin errors++; $display("FAIL good_dark: got %0d expected 200", o_dark_max); end
    checks++; if ({o_valid, o_bypass} !== 2'b10) begin errors++; $display("FAIL good_valid_bypass: got %b expected 10", {o_valid, o_bypass}); end
    checks++; if (o_frame_cnt !== 16'd1) begin errors++; $display("FAIL good_cnt: got %0d expected 1", o_frame_cnt); end
    checks++; if ({o_frame_done, o_frame_err} !== 2'b10) begin errors++; $display("FAIL good_pulses: got %b expected 10", {o_frame_done, o_frame_err}); end
    tick();
    checks++; if (o_frame_done !== 1'b0) begin errors++; $display("FAIL good_done_width: got %b expected 0", o_frame_done); end
  endtask

  task automatic test_smoothing();
    logic [7:0] maxes [4] = '{8'd240, 8'd100, 8'd183, 8'd90};
    logic [7:0] exps  [4] = '{8'd210, 8'd182, 8'd183, 8'd159};
    for (int k = 0; k < 4; k++) begin
      send_pixels(8, maxes[k]);
      vs_pulse();
      checks++; if (o_dark_max !== exps[k]) begin errors++; $display("FAIL smooth_dark[%0d]: got %0d expected %0d", k, o_dark_max, exps[k]); end
      checks++; if (o_frame_cnt !== 16'(k + 2)) begin errors++; $display("FAIL smooth_cnt[%0d]: got %0d expected %0d", k, o_frame_cnt, k + 2); end
      checks++; if (o_frame_done !== 1'b1) begin errors++; $display("FAIL smooth_done[%0d]: got %b expected 1", k, o_frame_done); end
    end
  endtask

  task automatic test_bad_count();
    send_pixels(7, 8'd20);
    vs_pulse();
    checks++; if ({o_frame_done, o_frame_err} !== 2'b11) begin errors++; $display("FAIL bad_pulses: got %b expected 11", {o_frame_done, o_frame_err}); end
    checks++; if (o_dark_max !== 8'd159) begin errors++; $display("FAIL bad_dark: got %0d expected 159", o_dark_max); end
    checks++; if (o_frame_cnt !== 16'd5) begin errors++; $display("FAIL bad_cnt: got %0d expected 5", o_frame_cnt); end
    checks++; if ({o_valid, o_bypass} !== 2'b10) begin errors++; $display("FAIL bad_valid_bypass: got %b expected 10", {o_valid, o_bypass}); end
  endtask

  task automatic test_manual();
    send_pixels(4, 8'd220);
    cfg_manual   = 1'b1;
    cfg_manual_a = 8'd50;
    send_pixels(4, 8'd220);
    checks++; if (o_dark_max !== 8'd159) begin errors++; $display("FAIL manual_midframe: got %0d expected 159", o_dark_max); end
    vs_pulse();
    checks++; if (o_dark_max !== 8'd50) begin errors++; $display("FAIL manual_dark: got %0d expected 50", o_dark_max); end
    checks++; if (o_frame_cnt !== 16'd5) begin errors++; $display("FAIL manual_cnt: got %0d expected 5", o_frame_cnt); end
    checks++; if ({o_frame_done, o_bypass} !== 2'b10) begin errors++; $display("FAIL manual_done_bypass: got %b expected 10", {o_frame_done, o_bypass}); end
    cfg_manual = 1'b0;
    send_pixels(8, 8'd250);
    vs_pulse();
    checks++; if (o_dark_max !== 8'd128) begin errors++; $display("FAIL revert_dark: got %0d expected 128", o_dark_max); end
    checks++; if (o_frame_cnt !== 16'd6) begin errors++; $display("FAIL revert_cnt: got %0d expected 6", o_frame_cnt); end
  endtask

  task automatic test_disable();
    send_pixels(3, 8'd60);
    cfg_en = 1'b0;
    tick();
    checks++; if ({o_valid, o_bypass} !== 2'b01) begin errors++; $display("FAIL disable_valid_bypass: got %b expected 01", {o_valid, o_bypass}); end
    send_pixels(5, 8'd60);
    vs_pulse();
    checks++; if (o_frame_done !== 1'b0) begin errors++; $display("FAIL disable_done: got %b expected 0", o_frame_done); end
    cfg_en = 1'b1;
    tick();
    checks++; if ({o_valid, o_bypass} !== 2'b01) begin errors++; $display("FAIL reenable_valid_bypass: got %b expected 01", {o_valid, o_bypass}); end
    checks++; if (o_dark_max !== 8'd128) begin errors++; $display("FAIL reenable_dark_hold: got %0d expected 128", o_dark_max); end
    send_pixels(2, 8'd10);
    vs_pulse();
    checks++; if (o_frame_done !== 1'b0) begin errors++; $display("FAIL resync_done: got %b expected 0", o_frame_done); end
    send_pixels(8, 8'd170);
    vs_pulse();
    checks++; if (o_dark_max !== 8'd170) begin errors++; $display("FAIL first_dark: got %0d expected 170", o_dark_max); end
    checks++; if ({o_frame_done, o_valid, o_bypass} !== 3'b110) begin errors++; $display("FAIL first_flags: got %b expected 110", {o_frame_done, o_valid, o_bypass}); end
  endtask

  task automatic test_first_clamp();
    cfg_en = 1'b0;
    tick();
    cfg_en = 1'b1;
    tick();
    vs_pulse();
    send_pixels(8, 8'd90);
    vs_pulse();
    checks++; if (o_dark_max !== 8'd128) begin errors++; $display("FAIL first_clamp_dark: got %0d expected 128", o_dark_max); end
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL first_clamp_valid: got %b expected 1", o_valid); end
  endtask

  task automatic test_reset_in_update();
    send_pixels(8, 8'd240);
    i_vsync = 1'b1;
    tick();
    reset   = 1'b1;
    i_vsync = 1'b0;
    tick();
    checks++; if (o_dark_max !== 8'd255) begin errors++; $display("FAIL rst_upd_dark: got %0d expected 255", o_dark_max); end
    checks++; if ({o_valid, o_bypass, o_frame_done, o_frame_err} !== 4'b0100) begin errors++; $display("FAIL rst_upd_flags: got %b expected 0100", {o_valid, o_bypass, o_frame_done, o_frame_err}); end
    checks++; if (o_frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_upd_cnt: got %0d expected 0", o_frame_cnt); end
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_smoothing();
    test_bad_count();
    test_manual();
    test_disable();
    test_first_clamp();
    test_reset_in_update();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
